upload_unpacker: RTL

UPLOAD_UNPACKER -- requirements
Module: upload_unpacker

---
 rtl/upload_unpacker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/upload_unpacker.sv
// Framed upload stream unpacker: strips the AA 44 header, passes payload through with zero latency,
// verifies the trailing additive checksum and reports framing status as single-cycle pulses.
module upload_unpacker #(
  parameter int unsigned MAX_LEN     = 256,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_in_data,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  output logic [7:0] o_out_data,
  output logic [7:0] o_out_source,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_out_sof,
  output logic       o_out_eof,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic       o_len_err,
  output logic       o_timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 2);

  typedef enum logic [2:0] {StIdle, StH1, StSrc, StLenH, StLenL, StData, StCksum} state_e;

  state_e        r_state, w_state_next;
  logic [7:0]    r_source, r_len_hi, r_sum;
  logic [15:0]   r_len, r_remaining;
  logic [TW-1:0] r_timer;
  logic          r_frame_ok, r_frame_err, r_len_err, r_timeout_err;

  logic          w_xfer, w_len_bad, w_timeout;
  logic [15:0]   w_len;
  logic [TW-1:0] w_timer_inc;

  // Payload is a combinational pass-through; backpressure goes straight upstream.
  assign o_in_ready  = (r_state == StData) ? i_out_ready : 1'b1;
  assign o_out_valid = (r_state == StData) && i_in_valid;
  assign o_out_data  = i_in_data;
  assign o_out_sof   = o_out_valid && (r_remaining == r_len);
  assign o_out_eof   = o_out_valid && (r_remaining == 16'd1);
  assign o_out_source = r_source;

  assign o_frame_ok    = r_frame_ok;
  assign o_frame_err   = r_frame_err;
  assign o_len_err     = r_len_err;
  assign o_timeout_err = r_timeout_err;

  assign w_xfer      = i_in_valid && o_in_ready;
  assign w_len       = {r_len_hi, i_in_data};
  assign w_len_bad   = (w_len == 16'd0) || (32'(w_len) > MAX_LEN);
  assign w_timer_inc = r_timer + TW'(1);
  // Any cycle without an input transfer (idle or stalled) counts towards the timeout.
  assign w_timeout   = (TIMEOUT_CYC != 0) && (r_state != StIdle) && !w_xfer &&
                       (w_timer_inc == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = StIdle;
    end else if (w_xfer) begin
      case (r_state)
        StIdle:  if (i_in_data == 8'hAA) w_state_next = StH1;
        StH1: begin
          if (i_in_data == 8'h44)      w_state_next = StSrc;
          else if (i_in_data != 8'hAA) w_state_next = StIdle;
        end
        StSrc:   w_state_next = StLenH;
        StLenH:  w_state_next = StLenL;
        StLenL:  w_state_next = w_len_bad ? StIdle : StData;
        StData:  if (r_remaining == 16'd1) w_state_next = StCksum;
        StCksum: w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_source      <= 8'h00;
      r_len_hi      <= 8'h00;
      r_sum         <= 8'h00;
      r_len         <= 16'd0;
      r_remaining   <= 16'd0;
      r_timer       <= '0;
      r_frame_ok    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_len_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_frame_ok    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_len_err     <= 1'b0;
      r_timeout_err <= w_timeout;

      if (r_state == StIdle || w_xfer || w_timeout) begin
        r_timer <= '0;
      end else begin
        r_timer <= w_timer_inc;
      end

      if (r_state == StH1) begin
        r_sum <= 8'h00;
      end

      if (w_xfer) begin
        case (r_state)
          StSrc: begin
            r_source <= i_in_data;
            r_sum    <= r_sum + i_in_data;
          end
          StLenH: begin
            r_len_hi <= i_in_data;
            r_sum    <= r_sum + i_in_data;
          end
          StLenL: begin
            r_len       <= w_len;
            r_remaining <= w_len;
            r_sum       <= r_sum + i_in_data;
            r_len_err   <= w_len_bad;
          end
          StData: begin
            r_remaining <= r_remaining - 16'd1;
            r_sum       <= r_sum + i_in_data;
          end
          StCksum: begin
            r_frame_ok  <= (r_sum == i_in_data);
            r_frame_err <= (r_sum != i_in_data);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
